// File: rtl/conv_mem_pkg.sv
// Shared types and constants for the convolution memory bank:
// loader state encoding, load-target select and result-drain mode.
package conv_mem_pkg;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    localparam logic TGT_IMG     = 1'b0;
    localparam logic TGT_FIL     = 1'b1;

    localparam logic OB_SERIAL   = 1'b0;
    localparam logic OB_PARALLEL = 1'b1;

endpackage

// File: rtl/conv_mem_array.sv
// Single-write, multi-read register-file array with registered read ports.
// Reads of addresses >= DEPTH return zero. Contents are not reset.
// Optional macro CONV_MEM_RDWR_BYPASS_EN: a read hitting the address being
// written in the same cycle returns the incoming write data instead of the
// old contents.
module conv_mem_array #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PORTS = 3,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rd_en,
    input  logic [PORTS*AW-1:0]    rd_addr,
    output logic [PORTS*WIDTH-1:0] rd_q
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PORTS*WIDTH-1:0] rd_q_q, rd_q_d;
    logic [AW-1:0]          ra;
    logic [WIDTH-1:0]       rv;

    // Storage write port; no reset so the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Per-port read mux with range check; q holds when rd_en is low.
    always_comb begin
        rd_q_d = rd_q_q;
        ra     = '0;
        rv     = '0;
        if (rd_en) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                ra = rd_addr[p*AW +: AW];
                rv = '0;
                if ({1'b0, ra} < (AW+1)'(DEPTH)) begin
                    rv = mem_q[ra];
`ifdef CONV_MEM_RDWR_BYPASS_EN
                    if (we && (waddr == ra)) begin
                        rv = wdata;
                    end
`endif
                end
                rd_q_d[p*WIDTH +: WIDTH] = rv;
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q_q <= '0;
        end else begin
            rd_q_q <= rd_q_d;
        end
    end

    assign rd_q = rd_q_q;

endmodule

// File: rtl/conv_mem_bank.sv
// Convolution memory bank: one IMG_DIM x IMG_DIM image array and one
// FIL_DIM x FIL_DIM filter array filled by a handshaked streaming loader,
// RD_PORTS registered read ports per array, and an OUT_DEPTH result buffer
// drained serially (lane 0) or in parallel.
// Optional macro CONV_MEM_RDWR_BYPASS_EN enables same-cycle write-to-read
// bypass inside both arrays.
module conv_mem_bank
    import conv_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IMG_DIM   = 4,
    parameter int unsigned FIL_DIM   = 3,
    parameter int unsigned RD_PORTS  = 3,
    parameter int unsigned OUT_DEPTH = 4,
    localparam int unsigned IMG_N    = IMG_DIM * IMG_DIM,
    localparam int unsigned IMG_AW   = $clog2(IMG_N),
    localparam int unsigned FIL_N    = FIL_DIM * FIL_DIM,
    localparam int unsigned FIL_AW   = $clog2(FIL_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_start,
    input  logic                         ld_tgt,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         ld_done,
    output logic                         img_full,
    output logic                         fil_full,
    input  logic                         rd_en,
    input  logic [RD_PORTS*IMG_AW-1:0]   img_addr,
    input  logic [RD_PORTS*FIL_AW-1:0]   fil_addr,
    output logic [RD_PORTS*DATA_W-1:0]   img_q,
    output logic [RD_PORTS*DATA_W-1:0]   fil_q,
    output logic                         rd_valid,
    input  logic                         ob_push,
    input  logic [DATA_W-1:0]            ob_data,
    input  logic                         ob_mode,
    input  logic                         ob_drain,
    output logic [OUT_DEPTH*DATA_W-1:0]  ob_q,
    output logic                         ob_qvalid,
    output logic                         ob_busy,
    output logic                         ob_full,
    output logic                         ob_ovf
);

    localparam int unsigned PTR_W = (IMG_AW > FIL_AW) ? IMG_AW : FIL_AW;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned OB_PW = $clog2(OUT_DEPTH);

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_e        state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, last_ptr;
    logic             tgt_q, tgt_d;
    logic             img_full_q, img_full_d;
    logic             fil_full_q, fil_full_d;
    logic             in_ready_q, in_ready_d;
    logic             ld_done_q, ld_done_d;
    logic             ld_we, img_we, fil_we;

    assign last_ptr = (tgt_q == TGT_FIL) ? PTR_W'(FIL_N - 1) : PTR_W'(IMG_N - 1);
    assign ld_we    = (state_q == LD_LOAD) && in_valid;
    assign img_we   = ld_we && (tgt_q == TGT_IMG);
    assign fil_we   = ld_we && (tgt_q == TGT_FIL);

    // Loader next-state; in_ready/ld_done are derived from the next state
    // so they come straight out of flops.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tgt_d      = tgt_q;
        img_full_d = img_full_q;
        fil_full_d = fil_full_q;
        case (state_q)
            LD_IDLE: begin
                if (ld_start) begin
                    state_d = LD_LOAD;
                    tgt_d   = ld_tgt;
                    ptr_d   = '0;
                    if (ld_tgt == TGT_IMG) img_full_d = 1'b0;
                    else                   fil_full_d = 1'b0;
                end
            end
            LD_LOAD: begin
                if (in_valid) begin
                    if (ptr_q == last_ptr) begin
                        state_d = LD_DONE;
                        if (tgt_q == TGT_IMG) img_full_d = 1'b1;
                        else                  fil_full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
        in_ready_d = (state_d == LD_LOAD);
        ld_done_d  = (state_d == LD_DONE);
    end

    // Loader state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            ptr_q      <= '0;
            tgt_q      <= TGT_IMG;
            img_full_q <= 1'b0;
            fil_full_q <= 1'b0;
            in_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tgt_q      <= tgt_d;
            img_full_q <= img_full_d;
            fil_full_q <= fil_full_d;
            in_ready_q <= in_ready_d;
            ld_done_q  <= ld_done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ld_done  = ld_done_q;
    assign img_full = img_full_q;
    assign fil_full = fil_full_q;

    // ------------------------------------------------------------------
    // Arrays
    // ------------------------------------------------------------------
    conv_mem_array #(
        .DEPTH (IMG_N),
        .WIDTH (DATA_W),
        .PORTS (RD_PORTS),
        .AW    (IMG_AW)
    ) u_img (
        .clk     (clk),
        .rst     (rst),
        .we      (img_we),
        .waddr   (ptr_q[IMG_AW-1:0]),
        .wdata   (in_data),
        .rd_en   (rd_en),
        .rd_addr (img_addr),
        .rd_q    (img_q)
    );

    conv_mem_array #(
        .DEPTH (FIL_N),
        .WIDTH (DATA_W),
        .PORTS (RD_PORTS),
        .AW    (FIL_AW)
    ) u_fil (
        .clk     (clk),
        .rst     (rst),
        .we      (fil_we),
        .waddr   (ptr_q[FIL_AW-1:0]),
        .wdata   (in_data),
        .rd_en   (rd_en),
        .rd_addr (fil_addr),
        .rd_q    (fil_q)
    );

    logic rd_valid_q;

    // Read-valid tracks rd_en with the one-cycle array latency.
    always_ff @(posedge clk) begin
        if (rst) rd_valid_q <= 1'b0;
        else     rd_valid_q <= rd_en;
    end

    assign rd_valid = rd_valid_q;

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]           ent_q [OUT_DEPTH];
    logic [DATA_W-1:0]           ent_d [OUT_DEPTH];
    logic [OB_PW-1:0]            wptr_q, wptr_d;
    logic [OB_PW-1:0]            rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            rem_q, rem_d;
    logic                        busy_q, busy_d;
    logic                        ovf_q, ovf_d;
    logic                        qvalid_q, qvalid_d;
    logic [OUT_DEPTH*DATA_W-1:0] obq_q, obq_d;
    logic                        full, drain_go, push_ok;

    assign full     = (count_q == CNT_W'(OUT_DEPTH));
    assign drain_go = ob_drain && (count_q != '0) && !busy_q;
    assign push_ok  = ob_push && !full && !busy_q && !drain_go;

    // Push/drain control. Serial drain keeps count until the last entry has
    // been presented, so ob_full stays asserted while ob_busy is high; the
    // rem counter tracks how many entries are still to be shown.
    always_comb begin
        ent_d    = ent_q;
        wptr_d   = wptr_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        obq_d    = obq_q;
        qvalid_d = 1'b0;
        ovf_d    = ovf_q;

        if (drain_go) ovf_d = 1'b0;
        if (ob_push && !push_ok) ovf_d = 1'b1;

        if (push_ok) begin
            ent_d[wptr_q] = ob_data;
            wptr_d        = wptr_q + OB_PW'(1);
            count_d       = count_q + CNT_W'(1);
        end

        if (drain_go) begin
            qvalid_d = 1'b1;
            if (ob_mode == OB_PARALLEL) begin
                for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                    obq_d[i*DATA_W +: DATA_W] = (CNT_W'(i) < count_q) ? ent_q[i] : '0;
                end
                count_d = '0;
                wptr_d  = '0;
            end else begin
                obq_d              = '0;
                obq_d[DATA_W-1:0]  = ent_q[0];
                busy_d             = 1'b1;
                rd_idx_d           = OB_PW'(1);
                rem_d              = count_q - CNT_W'(1);
            end
        end else if (busy_q) begin
            if (rem_q != '0) begin
                obq_d[DATA_W-1:0] = ent_q[rd_idx_q];
                rd_idx_d          = rd_idx_q + OB_PW'(1);
                rem_d             = rem_q - CNT_W'(1);
                qvalid_d          = 1'b1;
            end else begin
                busy_d  = 1'b0;
                count_d = '0;
                wptr_d  = '0;
            end
        end
    end

    // Buffer entries carry no reset; unwritten lanes are masked by count.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    // Buffer control and registered drain outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            qvalid_q <= 1'b0;
            obq_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            qvalid_q <= qvalid_d;
            obq_q    <= obq_d;
        end
    end

    assign ob_q      = obq_q;
    assign ob_qvalid = qvalid_q;
    assign ob_busy   = busy_q;
    assign ob_full   = full;
    assign ob_ovf    = ovf_q;

endmodule

// File: tb/tb_conv_mem_bank.sv
// Directed self-checking bench for conv_mem_bank with scoreboard queues
// for read data and drain data; memory contents tracked by a bench model.
module tb_conv_mem_bank;
    import conv_mem_pkg::*;

`ifdef CONV_MEM_RDWR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0, ld_tgt = 1'b0, in_valid = 1'b0;
    logic        in_ready, ld_done, img_full, fil_full;
    logic [7:0]  in_data = '0;
    logic        rd_en = 1'b0;
    logic [11:0] img_addr = '0, fil_addr = '0;
    logic [23:0] img_q, fil_q;
    logic        rd_valid;
    logic        ob_push = 1'b0, ob_mode = 1'b0, ob_drain = 1'b0;
    logic [7:0]  ob_data = '0;
    logic [31:0] ob_q;
    logic        ob_qvalid, ob_busy, ob_full, ob_ovf;

    always #5 clk = ~clk;

    conv_mem_bank #(
        .DATA_W    (8),
        .IMG_DIM   (4),
        .FIL_DIM   (3),
        .RD_PORTS  (3),
        .OUT_DEPTH (4)
    ) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_tgt(ld_tgt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ld_done(ld_done), .img_full(img_full), .fil_full(fil_full),
        .rd_en(rd_en), .img_addr(img_addr), .fil_addr(fil_addr),
        .img_q(img_q), .fil_q(fil_q), .rd_valid(rd_valid),
        .ob_push(ob_push), .ob_data(ob_data), .ob_mode(ob_mode),
        .ob_drain(ob_drain), .ob_q(ob_q), .ob_qvalid(ob_qvalid),
        .ob_busy(ob_busy), .ob_full(ob_full), .ob_ovf(ob_ovf)
    );

    typedef struct {
        logic [23:0] img;
        logic [23:0] fil;
    } rd_exp_t;

    rd_exp_t     rd_sb[$];
    logic [7:0]  ser_sb[$];
    logic [31:0] par_sb[$];

    logic [7:0]  img_m [16];
    logic [7:0]  fil_m [9];
    logic [7:0]  ld_data [16];

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_img(input int unsigned a);
        return (a < 16) ? img_m[a] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_fil(input int unsigned a);
        return (a < 9) ? fil_m[a] : 8'h00;
    endfunction

    task automatic do_read(input int unsigned i0, input int unsigned i1, input int unsigned i2,
                           input int unsigned f0, input int unsigned f1, input int unsigned f2);
        rd_exp_t e;
        rd_en    = 1'b1;
        img_addr = {4'(i2), 4'(i1), 4'(i0)};
        fil_addr = {4'(f2), 4'(f1), 4'(f0)};
        e.img = {exp_img(i2), exp_img(i1), exp_img(i0)};
        e.fil = {exp_fil(f2), exp_fil(f1), exp_fil(f0)};
        rd_sb.push_back(e);
        tick();
        rd_en = 1'b0;
        check("rd_valid", rd_valid, 1);
        e = rd_sb.pop_front();
        check("img_q", img_q, e.img);
        check("fil_q", fil_q, e.fil);
    endtask

    // Streams ld_data[0..n-1]; optionally toggles in_valid and snoops a read
    // of the address being written at beat index 'snoop'.
    task automatic do_load(input logic tgt, input int unsigned n, input bit toggle,
                           input int snoop, output int unsigned done_cyc);
        int unsigned cyc = 0;
        int unsigned writes = 0;
        bit          v;
        bit          snooped;
        rd_exp_t     e;
        ld_tgt   = tgt;
        ld_start = 1'b1;
        in_valid = 1'b0;
        tick();
        ld_start = 1'b0;
        cyc = 1;
        check("full_cleared", (tgt == TGT_IMG) ? img_full : fil_full, 0);
        while (writes < n && cyc < 100) begin
            check("in_ready_load", in_ready, 1);
            check("ld_done_low", ld_done, 0);
            v = !toggle || (cyc % 2 == 1);
            in_valid = v;
            in_data  = ld_data[writes];
            snooped  = 1'b0;
            if (v && int'(writes) == snoop) begin
                snooped  = 1'b1;
                rd_en    = 1'b1;
                img_addr = {3{4'(writes)}};
                fil_addr = '0;
                e.img = {3{BYPASS ? ld_data[writes] : exp_img(writes)}};
                e.fil = {3{exp_fil(0)}};
                rd_sb.push_back(e);
            end
            if (v) begin
                if (tgt == TGT_IMG) img_m[writes] = ld_data[writes];
                else                fil_m[writes] = ld_data[writes];
                writes++;
            end
            tick();
            cyc++;
            in_valid = 1'b0;
            if (snooped) begin
                rd_en = 1'b0;
                e = rd_sb.pop_front();
                check("rdwr_img_q", img_q, e.img);
                check("rdwr_fil_q", fil_q, e.fil);
            end
        end
        done_cyc = cyc;
        check("ld_done_pulse", ld_done, 1);
        check("in_ready_done", in_ready, 0);
        check("full_set", (tgt == TGT_IMG) ? img_full : fil_full, 1);
        tick();
        check("ld_done_clear", ld_done, 0);
        check("in_ready_idle", in_ready, 0);
    endtask

    task automatic push_ob(input logic [7:0] d);
        ob_push = 1'b1;
        ob_data = d;
        tick();
        ob_push = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned dc;
        int          wait_cyc;
        logic [7:0]  e8;
        logic [23:0] held_img;

        // Reset values
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_img_full", img_full, 0);
        check("rst_fil_full", fil_full, 0);
        check("rst_img_q", img_q, 0);
        check("rst_fil_q", fil_q, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ob_q", ob_q, 0);
        check("rst_ob_qvalid", ob_qvalid, 0);
        check("rst_ob_busy", ob_busy, 0);
        check("rst_ob_full", ob_full, 0);
        check("rst_ob_ovf", ob_ovf, 0);
        rst = 1'b0;
        tick();

        // Image 0..15, in_valid held high
        for (int i = 0; i < 16; i++) ld_data[i] = 8'(i);
        do_load(TGT_IMG, 16, 1'b0, -1, dc);
        check("img_done_cycle", dc, 17);

        // Filter 1..9, in_valid toggling
        for (int i = 0; i < 9; i++) ld_data[i] = 8'(i + 1);
        do_load(TGT_FIL, 9, 1'b1, -1, dc);
        check("fil_done_cycle", dc, 18);
        check("img_full_kept", img_full, 1);

        // Reads, including out-of-range filter addresses
        do_read(1, 4, 7, 15, 10, 5);
        held_img = {8'd7, 8'd4, 8'd1};
        img_addr = {4'd9, 4'd9, 4'd9};
        tick();
        check("rd_valid_low", rd_valid, 0);
        check("img_q_hold", img_q, held_img);
        do_read(0, 15, 8, 0, 8, 9);
        for (int k = 0; k < 6; k++)
            do_read($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));

        // Serial drain
        for (int i = 0; i < 4; i++) push_ob(8'(12 + i));
        check("ser_full", ob_full, 1);
        check("ser_ovf", ob_ovf, 0);
        ob_mode  = OB_SERIAL;
        ob_drain = 1'b1;
        for (int i = 0; i < 4; i++) ser_sb.push_back(8'(12 + i));
        tick();
        ob_drain = 1'b0;
        wait_cyc = 0;
        while (!ob_qvalid && wait_cyc < 8) begin
            tick();
            wait_cyc++;
        end
        check("ser_latency", wait_cyc, 0);
        while (ser_sb.size() > 0) begin
            e8 = ser_sb.pop_front();
            check("ser_lane0", ob_q[7:0], e8);
            check("ser_qvalid", ob_qvalid, 1);
            check("ser_busy", ob_busy, 1);
            tick();
        end
        check("ser_busy_end", ob_busy, 0);
        check("ser_qvalid_end", ob_qvalid, 0);
        check("ser_full_end", ob_full, 0);

        // Parallel drain after an overflowing push
        for (int i = 0; i < 4; i++) push_ob(8'(12 + i));
        check("par_full", ob_full, 1);
        check("par_ovf_pre", ob_ovf, 0);
        push_ob(8'd99);
        check("par_ovf_5th", ob_ovf, 1);
        ob_mode  = OB_PARALLEL;
        ob_drain = 1'b1;
        par_sb.push_back({8'd15, 8'd14, 8'd13, 8'd12});
        tick();
        ob_drain = 1'b0;
        check("par_qvalid", ob_qvalid, 1);
        check("par_q", ob_q, par_sb.pop_front());
        check("par_ovf_clr", ob_ovf, 0);
        check("par_busy", ob_busy, 0);
        tick();
        check("par_qvalid_1cyc", ob_qvalid, 0);
        check("par_full_clr", ob_full, 0);

        // Partial parallel drain with a push in the drain cycle
        push_ob(8'd7);
        push_ob(8'd8);
        ob_drain = 1'b1;
        ob_push  = 1'b1;
        ob_data  = 8'd55;
        par_sb.push_back({8'd0, 8'd0, 8'd8, 8'd7});
        tick();
        ob_drain = 1'b0;
        ob_push  = 1'b0;
        check("part_qvalid", ob_qvalid, 1);
        check("part_q", ob_q, par_sb.pop_front());
        check("part_ovf", ob_ovf, 1);
        push_ob(8'd3);
        ob_drain = 1'b1;
        par_sb.push_back({8'd0, 8'd0, 8'd0, 8'd3});
        tick();
        ob_drain = 1'b0;
        check("one_q", ob_q, par_sb.pop_front());
        check("one_ovf_clr", ob_ovf, 0);
        tick();
        ob_drain = 1'b1;
        tick();
        ob_drain = 1'b0;
        check("empty_drain_qvalid", ob_qvalid, 0);
        check("empty_drain_busy", ob_busy, 0);

        // Reset in the middle of an image load
        for (int i = 0; i < 16; i++) ld_data[i] = 8'(100 + i);
        ld_tgt   = TGT_IMG;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("mid_img_full", img_full, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = ld_data[i];
            img_m[i] = ld_data[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_img_full", img_full, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_ld_done", ld_done, 0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("mid_rst_idle", in_ready, 0);
        for (int i = 0; i < 16; i++) ld_data[i] = 8'(200 + i);
        do_load(TGT_IMG, 16, 1'b0, -1, dc);
        check("reload_done_cycle", dc, 17);
        do_read(0, 5, 15, 0, 1, 2);

        // Read/write collision on image address 3
        for (int i = 0; i < 16; i++) ld_data[i] = 8'(50 + i);
        ld_data[3] = 8'd99;
        do_load(TGT_IMG, 16, 1'b0, 3, dc);
        check("snoop_done_cycle", dc, 17);
        do_read(3, 2, 4, 3, 4, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
